// File: rtl/fault_monitor_core.sv
// Invariant fault monitor: persistence-filtered violation detection with a sticky alarm,
// clear handshake, per-invariant trip flags, first-trip index and saturating event count.
module fault_monitor_core #(
  parameter int unsigned NumInvariants = 11,
  parameter int unsigned ViolThreshold = 1,
  parameter int unsigned FaultCntWidth = 8,
  parameter bit          StickyAlarm   = 1'b1,
  localparam int unsigned IdxWidth    = (NumInvariants > 1) ? $clog2(NumInvariants) : 1,
  localparam int unsigned CntWidth    = $clog2(ViolThreshold + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumInvariants-1:0] invariant_i,
  input  logic [NumInvariants-1:0] enable_i,
  input  logic [NumInvariants-1:0] mask_i,
  input  logic                     arm_i,
  input  logic                     alarm_clr_i,
  output logic                     alarm_o,
  output logic                     armed_o,
  output logic [NumInvariants-1:0] trip_vec_o,
  output logic                     first_valid_o,
  output logic [IdxWidth-1:0]      first_idx_o,
  output logic [FaultCntWidth-1:0] fault_cnt_o,
  output logic                     clr_ack_o
);

  localparam logic [CntWidth-1:0] CntSat  = CntWidth'(ViolThreshold);
  localparam logic [CntWidth-1:0] CntTrip = CntWidth'(ViolThreshold - 1);

  typedef enum logic [1:0] {StDisarmed, StMonitor, StAlarm, StClear} state_e;

  state_e state_q, state_d;

  logic [NumInvariants-1:0] viol, trip, sat;
  logic [CntWidth-1:0]      cnt_q [NumInvariants];
  logic [CntWidth-1:0]      cnt_d [NumInvariants];
  logic                     counting;
  logic [IdxWidth-1:0]      low_idx;

  logic                     alarm_d, armed_d, first_valid_d, clr_ack_d;
  logic [NumInvariants-1:0] trip_vec_d;
  logic [IdxWidth-1:0]      first_idx_d;
  logic [FaultCntWidth-1:0] fault_cnt_d;

  assign counting = (state_q == StMonitor) || (state_q == StAlarm);

  // Run-length counters; any gap in the violation (or an idle state) restarts the run.
  always_comb begin
    viol    = enable_i & ~mask_i & ~invariant_i;
    trip    = '0;
    sat     = '0;
    low_idx = '0;
    for (int i = 0; i < NumInvariants; i++) begin
      trip[i]  = viol[i] & counting & (cnt_q[i] == CntTrip);
      sat[i]   = viol[i] & (cnt_q[i] == CntSat);
      cnt_d[i] = '0;
      if (viol[i] && counting) begin
        cnt_d[i] = (cnt_q[i] == CntSat) ? cnt_q[i] : cnt_q[i] + CntWidth'(1);
      end
    end
    for (int i = NumInvariants - 1; i >= 0; i--) begin
      if (trip[i]) low_idx = IdxWidth'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StDisarmed;
      for (int i = 0; i < NumInvariants; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NumInvariants; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDisarmed: if (arm_i) state_d = StMonitor;
      StMonitor: begin
        if (|trip)       state_d = StAlarm;
        else if (!arm_i) state_d = StDisarmed;
      end
      StAlarm:    if (alarm_clr_i) state_d = StClear;
      StClear:    state_d = arm_i ? StMonitor : StDisarmed;
      default:    state_d = StDisarmed;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    trip_vec_d    = trip_vec_o | trip;
    first_valid_d = first_valid_o;
    first_idx_d   = first_idx_o;
    fault_cnt_d   = fault_cnt_o;
    if (state_q == StMonitor && state_d == StAlarm) begin
      first_valid_d = 1'b1;
      first_idx_d   = low_idx;
      if (fault_cnt_o != {FaultCntWidth{1'b1}}) begin
        fault_cnt_d = fault_cnt_o + FaultCntWidth'(1);
      end
    end
    if (state_d == StClear) begin
      trip_vec_d    = '0;
      first_valid_d = 1'b0;
      first_idx_d   = '0;
    end
    alarm_d   = (state_d == StAlarm) && (StickyAlarm || (|trip) || (|sat));
    armed_d   = (state_d != StDisarmed);
    clr_ack_d = (state_d == StClear);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      alarm_o       <= 1'b0;
      armed_o       <= 1'b0;
      trip_vec_o    <= '0;
      first_valid_o <= 1'b0;
      first_idx_o   <= '0;
      fault_cnt_o   <= '0;
      clr_ack_o     <= 1'b0;
    end else begin
      alarm_o       <= alarm_d;
      armed_o       <= armed_d;
      trip_vec_o    <= trip_vec_d;
      first_valid_o <= first_valid_d;
      first_idx_o   <= first_idx_d;
      fault_cnt_o   <= fault_cnt_d;
      clr_ack_o     <= clr_ack_d;
    end
  end

endmodule
